// File: rtl/pulse_sequencer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sequencer_ctrl_if
// Description : Control, configuration and status bundle for the pulse
//               sequencer. The master drives trigger/arm/abort/burst and
//               config writes and observes the pulse outputs and status.
//               The slave (the sequencer) is the mirror image.
//   trig_in   : external trigger, asynchronous, active high
//   arm/abort : single-cycle requests
//   burst_len : shots per arm, 0 = continuous
//   cfg_*     : shadow register write port
//   ch_out    : channel pulses; busy/done/shot_cnt/overrun : status
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_sequencer_ctrl_if #(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 4
);
    logic              trig_in;
    logic              arm;
    logic              abort;
    logic [15:0]       burst_len;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [CNT_W-1:0]  cfg_data;
    logic [NUM_CH-1:0] ch_out;
    logic              busy;
    logic              done;
    logic [15:0]       shot_cnt;
    logic              overrun;

    modport master (
        output trig_in, arm, abort, burst_len, cfg_we, cfg_addr, cfg_data,
        input  ch_out, busy, done, shot_cnt, overrun
    );

    modport slave (
        input  trig_in, arm, abort, burst_len, cfg_we, cfg_addr, cfg_data,
        output ch_out, busy, done, shot_cnt, overrun
    );
endinterface
`default_nettype wire

// File: rtl/pulse_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sequencer_ctrl
// Description : Armed, trigger-started frame sequencer. Each accepted trigger
//               runs one frame of frame_len cycles in which every channel is
//               high for its programmed start/width window. Timing lives in
//               shadow registers that are copied to active ones at trigger
//               acceptance, so a running frame is never disturbed by writes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pulse_sequencer_ctrl_if.slave (control, config, status)
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sequencer_ctrl #(
    parameter int CNT_W     = 16,
    parameter int NUM_CH    = 4,
    parameter int DEF_FRAME = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pulse_sequencer_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_burst;
    logic [15:0]        r_shot;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;
    logic [NUM_CH-1:0]  r_ch_out;
    logic [CNT_W-1:0]   r_frame_sh;
    logic [CNT_W-1:0]   r_frame_act;
    logic               r_sync1, r_sync2, r_sync3, r_evt;

    logic [NUM_CH-1:0]  w_win;
    logic [CNT_W-1:0]   w_frame_last;
    logic               w_accept;
    logic               w_frame_end;
    logic               w_last_shot;

    // Trigger: two-flop synchronizer, then a registered rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_sync1 <= bus.trig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_evt   <= r_sync2 & ~r_sync3;
        end
    end

    assign w_accept     = (r_state == S_ARMED) && r_evt && !bus.abort;
    // A programmed frame length of zero still runs a single cycle.
    assign w_frame_last = (r_frame_act == '0) ? '0 : r_frame_act - CNT_W'(1);
    assign w_frame_end  = (r_state == S_RUN) && (r_cnt == w_frame_last);
    assign w_last_shot  = (r_burst != 16'd0) && (r_shot == r_burst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_sh  <= CNT_W'(DEF_FRAME);
            r_frame_act <= CNT_W'(DEF_FRAME);
        end else begin
            if (bus.cfg_we && bus.cfg_addr == 4'd15)
                r_frame_sh <= bus.cfg_data;
            if (w_accept)
                r_frame_act <= r_frame_sh;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [3:0] c_addr_start = 4'(2 * i);
        localparam logic [3:0] c_addr_width = 4'(2 * i + 1);
        logic [CNT_W-1:0] r_start_sh, r_width_sh, r_start_act, r_width_act;
        logic [CNT_W:0]   w_end;

        // Address 15 always belongs to the frame length, even with 8 channels.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_start_sh  <= '0;
                r_width_sh  <= '0;
                r_start_act <= '0;
                r_width_act <= '0;
            end else begin
                if (bus.cfg_we && bus.cfg_addr == c_addr_start)
                    r_start_sh <= bus.cfg_data;
                if (bus.cfg_we && bus.cfg_addr == c_addr_width && bus.cfg_addr != 4'd15)
                    r_width_sh <= bus.cfg_data;
                // Same-cycle writes land in shadow only: the copy sees old values.
                if (w_accept) begin
                    r_start_act <= r_start_sh;
                    r_width_act <= r_width_sh;
                end
            end
        end

        // One extra bit so start+width never wraps back into the frame.
        assign w_end    = {1'b0, r_start_act} + {1'b0, r_width_act};
        assign w_win[i] = (r_cnt >= r_start_act) && ({1'b0, r_cnt} < w_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_burst   <= 16'd0;
            r_shot    <= 16'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_ch_out  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_ch_out <= '0;
            if (bus.abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.arm) begin
                            r_state   <= S_ARMED;
                            r_busy    <= 1'b1;
                            r_burst   <= bus.burst_len;
                            r_shot    <= 16'd0;
                            r_overrun <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (r_evt) begin
                            r_state <= S_RUN;
                            r_cnt   <= '0;
                            r_shot  <= (r_shot == 16'hFFFF) ? r_shot : r_shot + 16'd1;
                        end
                    end
                    S_RUN: begin
                        r_ch_out <= w_win;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        if (r_evt)
                            r_overrun <= 1'b1;
                        // Always pass through ARMED so back-to-back frames stay separate.
                        if (w_frame_end) begin
                            if (w_last_shot) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_ARMED;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ch_out   = r_ch_out;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.shot_cnt = r_shot;
    assign bus.overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_sequencer_ctrl
// Description : Directed self-checking bench for pulse_sequencer_ctrl.
//               Index k in the capture history is the k-th rising edge after
//               trig_in is raised; the trigger is accepted at edge 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_sequencer_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] h_ch   [0:255];
    logic       h_done [0:255];
    logic       h_busy [0:255];
    logic       h_ovr  [0:255];

    always #5 clk = ~clk;

    pulse_sequencer_ctrl_if #(.CNT_W(16), .NUM_CH(4)) bus ();

    pulse_sequencer_ctrl #(.CNT_W(16), .NUM_CH(4), .DEF_FRAME(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic do_arm(input logic [15:0] blen);
        bus.burst_len = blen;
        bus.arm       = 1'b1;
        tick();
        bus.arm       = 1'b0;
    endtask

    // Raise trig_in, record n edges; optional second trigger, config write
    // and abort are injected after sampling the given index.
    task automatic capture(input int n, input int trig2_at, input int wr_at,
                           input logic [3:0] wr_addr, input logic [15:0] wr_data,
                           input int abort_at);
        bus.trig_in = 1'b1;
        for (int k = 1; k <= n; k++) begin
            tick();
            h_ch[k]   = bus.ch_out;
            h_done[k] = bus.done;
            h_busy[k] = bus.busy;
            h_ovr[k]  = bus.overrun;
            bus.cfg_we = 1'b0;
            bus.abort  = 1'b0;
            if (k == 3) bus.trig_in = 1'b0;
            if (trig2_at != 0 && k == trig2_at) bus.trig_in = 1'b1;
            if (trig2_at != 0 && k == trig2_at + 3) bus.trig_in = 1'b0;
            if (k == wr_at) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = wr_addr;
                bus.cfg_data = wr_data;
            end
            if (k == abort_at) bus.abort = 1'b1;
        end
        bus.trig_in = 1'b0;
        bus.cfg_we  = 1'b0;
        bus.abort   = 1'b0;
    endtask

    function automatic int first_high(input int b, input int n);
        for (int k = 1; k <= n; k++) if (h_ch[k][b]) return k;
        return 0;
    endfunction

    function automatic int count_high(input int b, input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (h_ch[k][b]) c++;
        return c;
    endfunction

    function automatic int done_idx(input int n);
        for (int k = 1; k <= n; k++) if (h_done[k]) return k;
        return 0;
    endfunction

    function automatic int done_count(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (h_done[k]) c++;
        return c;
    endfunction

    task automatic test_reset();
        checks++; if (bus.ch_out !== 4'd0) begin errors++; $display("FAIL reset_ch got %0h exp 0", bus.ch_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", bus.done); end
        checks++; if (bus.shot_cnt !== 16'd0) begin errors++; $display("FAIL reset_shot got %0d exp 0", bus.shot_cnt); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %0b exp 0", bus.overrun); end
    endtask

    task automatic test_defaults();
        cfg_write(4'd0, 16'd10); cfg_write(4'd1, 16'd10);
        cfg_write(4'd2, 16'd15); cfg_write(4'd3, 16'd15);
        cfg_write(4'd15, 16'd48);
        do_arm(16'd1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL def_busy_armed got %0b exp 1", bus.busy); end
        capture(60, 0, 0, 4'd0, 16'd0, 0);
        checks++; if (first_high(0, 60) != 15) begin errors++; $display("FAIL def_ch0_first got %0d exp 15", first_high(0, 60)); end
        checks++; if (count_high(0, 60) != 10) begin errors++; $display("FAIL def_ch0_len got %0d exp 10", count_high(0, 60)); end
        checks++; if (first_high(1, 60) != 20) begin errors++; $display("FAIL def_ch1_first got %0d exp 20", first_high(1, 60)); end
        checks++; if (count_high(1, 60) != 15) begin errors++; $display("FAIL def_ch1_len got %0d exp 15", count_high(1, 60)); end
        checks++; if (count_high(2, 60) != 0) begin errors++; $display("FAIL def_ch2_len got %0d exp 0", count_high(2, 60)); end
        checks++; if (done_idx(60) != 52) begin errors++; $display("FAIL def_done_idx got %0d exp 52", done_idx(60)); end
        checks++; if (done_count(60) != 1) begin errors++; $display("FAIL def_done_cnt got %0d exp 1", done_count(60)); end
        checks++; if (h_busy[51] !== 1'b1 || h_busy[52] !== 1'b0) begin errors++; $display("FAIL def_busy_drop got %0b%0b exp 10", h_busy[51], h_busy[52]); end
        checks++; if (bus.shot_cnt !== 16'd1) begin errors++; $display("FAIL def_shot got %0d exp 1", bus.shot_cnt); end
    endtask

    task automatic test_burst();
        do_arm(16'd3);
        for (int s = 1; s <= 4; s++) begin
            capture(100, 0, 0, 4'd0, 16'd0, 0);
            if (s <= 3) begin
                checks++; if (first_high(0, 100) != 15 || count_high(0, 100) != 10) begin
                    errors++; $display("FAIL burst_ch0 shot %0d got first %0d len %0d exp 15/10", s, first_high(0, 100), count_high(0, 100)); end
            end else begin
                checks++; if (count_high(0, 100) != 0) begin errors++; $display("FAIL burst_extra_ch0 got %0d exp 0", count_high(0, 100)); end
            end
            checks++; if (done_count(100) != ((s == 3) ? 1 : 0)) begin
                errors++; $display("FAIL burst_done shot %0d got %0d exp %0d", s, done_count(100), (s == 3) ? 1 : 0); end
            checks++; if (bus.shot_cnt !== 16'((s > 3) ? 3 : s)) begin
                errors++; $display("FAIL burst_shot shot %0d got %0d exp %0d", s, bus.shot_cnt, (s > 3) ? 3 : s); end
        end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL burst_ovr got %0b exp 0", bus.overrun); end
    endtask

    task automatic test_overrun();
        cfg_write(4'd15, 16'd200);
        do_arm(16'd1);
        capture(220, 50, 0, 4'd0, 16'd0, 0);
        checks++; if (h_ovr[53] !== 1'b0 || h_ovr[54] !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b%0b exp 01", h_ovr[53], h_ovr[54]); end
        checks++; if (count_high(0, 220) != 10) begin errors++; $display("FAIL ovr_no_restart got %0d exp 10", count_high(0, 220)); end
        checks++; if (done_idx(220) != 204) begin errors++; $display("FAIL ovr_done_idx got %0d exp 204", done_idx(220)); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b exp 1", bus.overrun); end
        do_arm(16'd1);
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b exp 0", bus.overrun); end
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    endtask

    task automatic test_shadow();
        cfg_write(4'd15, 16'd48);
        do_arm(16'd2);
        capture(60, 0, 3, 4'd0, 16'd5, 0);
        checks++; if (first_high(0, 60) != 15) begin errors++; $display("FAIL shadow_shot1 got %0d exp 15", first_high(0, 60)); end
        capture(60, 0, 0, 4'd0, 16'd0, 0);
        checks++; if (first_high(0, 60) != 10 || count_high(0, 60) != 10) begin
            errors++; $display("FAIL shadow_shot2 got first %0d len %0d exp 10/10", first_high(0, 60), count_high(0, 60)); end
    endtask

    task automatic test_abort();
        cfg_write(4'd0, 16'd10);
        do_arm(16'd1);
        capture(60, 0, 0, 4'd0, 16'd0, 16);
        checks++; if (h_ch[16][0] !== 1'b1 || h_ch[17] !== 4'd0) begin errors++; $display("FAIL abort_ch got %0b/%0h exp 1/0", h_ch[16][0], h_ch[17]); end
        checks++; if (count_high(0, 60) != 2) begin errors++; $display("FAIL abort_len got %0d exp 2", count_high(0, 60)); end
        checks++; if (h_busy[17] !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", h_busy[17]); end
        checks++; if (done_count(60) != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_count(60)); end
        checks++; if (bus.shot_cnt !== 16'd1) begin errors++; $display("FAIL abort_shot got %0d exp 1", bus.shot_cnt); end
    endtask

    task automatic test_boundaries();
        cfg_write(4'd4, 16'd5);  cfg_write(4'd5, 16'd0);
        cfg_write(4'd6, 16'd40); cfg_write(4'd7, 16'd20);
        do_arm(16'd1);
        capture(60, 0, 0, 4'd0, 16'd0, 0);
        checks++; if (count_high(2, 60) != 0) begin errors++; $display("FAIL width0 got %0d exp 0", count_high(2, 60)); end
        checks++; if (first_high(3, 60) != 45 || count_high(3, 60) != 8) begin
            errors++; $display("FAIL trunc got first %0d len %0d exp 45/8", first_high(3, 60), count_high(3, 60)); end
        cfg_write(4'd15, 16'd0); cfg_write(4'd0, 16'd0); cfg_write(4'd1, 16'd5);
        do_arm(16'd1);
        capture(20, 0, 0, 4'd0, 16'd0, 0);
        checks++; if (done_idx(20) != 5) begin errors++; $display("FAIL frame0_done got %0d exp 5", done_idx(20)); end
        checks++; if (first_high(0, 20) != 5 || count_high(0, 20) != 1) begin
            errors++; $display("FAIL frame0_ch0 got first %0d len %0d exp 5/1", first_high(0, 20), count_high(0, 20)); end
    endtask

    task automatic test_async_reset();
        cfg_write(4'd15, 16'd48); cfg_write(4'd0, 16'd0); cfg_write(4'd1, 16'd30);
        do_arm(16'd1);
        capture(20, 0, 0, 4'd0, 16'd0, 0);
        checks++; if (h_ch[20][0] !== 1'b1) begin errors++; $display("FAIL arst_pre_ch0 got %0b exp 1", h_ch[20][0]); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.ch_out !== 4'd0 || bus.busy !== 1'b0 || bus.shot_cnt !== 16'd0) begin
            errors++; $display("FAIL arst_outputs got ch %0h busy %0b shot %0d exp 0/0/0", bus.ch_out, bus.busy, bus.shot_cnt); end
        #2 rst_n = 1'b1;
        tick();
        do_arm(16'd1);
        capture(80, 0, 0, 4'd0, 16'd0, 0);
        checks++; if (count_high(0, 80) != 0) begin errors++; $display("FAIL arst_regs_clear got %0d exp 0", count_high(0, 80)); end
        checks++; if (done_idx(80) != 68) begin errors++; $display("FAIL arst_def_frame got %0d exp 68", done_idx(80)); end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.trig_in   = 1'b0;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        bus.burst_len = 16'd0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 4'd0;
        bus.cfg_data  = 16'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_defaults();
        test_burst();
        test_overrun();
        test_shadow();
        test_abort();
        test_boundaries();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pulse_sequencer_ctrl.md
Name: pulse_sequencer_ctrl

Overview:
- Programmable controller for the trigger/delay pulse chain.
- Arms on command and waits for an external trigger pulse, e.g. 16 kHz from the function generator.
- On each accepted trigger, runs one timed frame in which NUM_CH outputs each assert for a programmable start/width window.
- Timing is held in CPU-writable shadow registers and repeats for a programmed burst of shots. This replaces hard-coded delay thresholds with a runtime-configurable schedule.

Parameters:
- CNT_W, 16, width of frame counter, start/width/frame-length registers
- NUM_CH, 4, number of pulse output channels (max 8)
- DEF_FRAME, 64, reset value of the frame-length register

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trig_in  in  1  external trigger, asynchronous to clk, active high
- arm  in  1  single-cycle arm request
- abort  in  1  single-cycle abort request
- burst_len  in  16  shots per arm; 0 = continuous
- cfg_we  in  1  config write strobe
- cfg_addr  in  4  2*i = start of ch i, 2*i+1 = width of ch i, 15 = frame length
- cfg_data  in  CNT_W  config write data
- ch_out  out  NUM_CH  registered channel pulses
- busy  out  1  high in ARMED or RUN
- done  out  1  one-cycle pulse when a burst completes
- shot_cnt  out  16  triggers accepted since last arm, saturating
- overrun  out  1  sticky: a trigger arrived while in RUN

Behaviour:
- Async reset (rst_n low): state IDLE, ch_out=0, busy=0, done=0, shot_cnt=0, overrun=0, counter=0, all start/width regs (shadow and active) = 0, frame length = DEF_FRAME.
- Trigger path: trig_in → 2-flop synchronizer → rising-edge detect. trig_evt is high exactly one cycle, 3 clk edges after the trig_in rise. A level held high gives one event only.
- Config writes: cfg_we writes shadow registers in any state. Writes to unmapped addresses are ignored.
- Shadow-to-active copy: at trigger acceptance all shadows copy to active. A write in the same cycle as acceptance lands in shadow only and takes effect on the next shot.
- Frame-length value 0 is treated as 1.
- FSM states: IDLE, ARMED, RUN.
- Priority each cycle: abort > arm > trig_evt.
- IDLE:
  - arm → ARMED.
  - On arm: latch burst_len, clear shot_cnt and overrun.
  - trig_evt is ignored (no overrun).
- ARMED: trig_evt → RUN, counter←0, shot_cnt←shot_cnt+1 (saturates at 0xFFFF).
- RUN:
  - Counter increments each cycle.
  - At counter==frame_len-1: if burst_len≠0 and shot_cnt==burst_len → IDLE with done=1 that cycle (registered; done high the cycle after the last RUN cycle); else → ARMED.
  - trig_evt in RUN sets overrun and is otherwise ignored.
  - arm in ARMED/RUN is ignored.
- abort in any state: → IDLE next edge, ch_out=0 next edge, no done, shot_cnt retained.
- Channel window:
  - ch_out[i] is registered and compares against the current counter.
  - ch_out[i] is high on the edge after counter==start_i through the edge after counter==start_i+width_i-1.
  - The sum start_i+width_i is computed in CNT_W+1 bits; there is no wrap.
  - width_i==0 → channel never asserts.
  - Window is truncated at the frame end; ch_out=0 whenever state≠RUN at the prior edge.
  - Consecutive frames never merge: at least one cycle in ARMED separates RUN frames.
- busy is registered: high iff state is ARMED or RUN.

Test Plan:
- Defaults: program ch0 start=10 width=10, ch1 start=15 width=15, frame=48, burst=1; arm, pulse trig_in → ch0 high exactly 10 cycles starting 11 cycles after trig_evt, ch1 high 15 cycles, done pulses once, shot_cnt=1, busy drops.
- Burst: burst_len=3, trigger every 100 cycles → three identical frames, done after third, fourth trigger ignored, shot_cnt=3, overrun=0.
- Overrun: frame=200, second trig_in 50 cycles after first → overrun=1, no restart, frame completes at 200 cycles; next arm clears overrun.
- Shadow timing: write ch0 start=5 in the acceptance cycle of shot 1 → shot 1 uses old start, shot 2 uses 5.
- Abort mid-frame: abort at counter=12 with ch0 high → ch_out=0 next edge, state IDLE, done stays 0, shot_cnt unchanged.
- Boundaries: width=0 → no pulse; start=40 width=20 with frame=48 → pulse truncated to 8 cycles; frame=0 → 1-cycle frame; async rst_n low mid-RUN → all outputs 0 immediately, regs default.
